// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority voting, per-word
// parity/frame/break flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int unsigned p_CLK_DIV    = 104,
  parameter int unsigned p_WORD_LEN   = 8,
  parameter int unsigned p_PARITY     = 0,
  parameter int unsigned p_STOP_BITS  = 1,
  parameter int unsigned p_FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx,
  input  logic                          i_rd,
  output logic [p_WORD_LEN-1:0]         o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_break,
  output logic                          o_dv,
  output logic [$clog2(p_FIFO_DEPTH):0] o_count,
  output logic                          o_overflow,
  output logic                          o_busy
);

  localparam int unsigned CntW = $clog2(p_CLK_DIV);
  localparam int unsigned Mid  = p_CLK_DIV / 2;
  localparam int unsigned PtrW = $clog2(p_FIFO_DEPTH);
  localparam int unsigned EntW = p_WORD_LEN + 3;
  localparam bit          HasParity = (p_PARITY != 0);

  localparam logic [3:0]      LastData = 4'(p_WORD_LEN - 1);
  localparam logic [3:0]      LastStop = 4'(p_STOP_BITS - 1);
  localparam logic [CntW-1:0] CntSmp0  = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntSmp1  = CntW'(Mid);
  localparam logic [CntW-1:0] CntDec   = CntW'(Mid + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(p_CLK_DIV - 1);
  localparam logic [PtrW:0]   CntFull  = (PtrW + 1)'(p_FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  logic            rx_meta_q, rxs_q, armed_q;
  logic [1:0]      vld_q;
  logic [CntW-1:0] cnt_q;
  logic            s0_q, s1_q;
  logic [3:0]      bit_q;
  logic [p_WORD_LEN-1:0] data_q;
  logic            par_bit_q, perr_q, ferr_q;

  logic start_ok, decide, maj, ones_odd, par_mismatch;
  logic frame_done, ferr_final, brk;
  logic [EntW-1:0] entry;

  assign start_ok     = armed_q & ~rxs_q;
  assign decide       = (cnt_q == CntDec);
  assign maj          = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign ones_odd     = (^data_q) ^ maj;
  assign par_mismatch = (p_PARITY == 1) ? ~ones_odd : ones_odd;

  // vld_q marks when rxs_q carries a real line sample; armed_q requires idle-high before a start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      vld_q     <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rxs_q     <= rx_meta_q;
      vld_q     <= {vld_q[0], 1'b1};
      if (frame_done && ferr_final) armed_q <= 1'b0;
      else if (vld_q[1] && rxs_q)   armed_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StStart;
      StStart:  if (decide) state_d = maj ? StIdle : StData;
      StData:   if (decide && bit_q == LastData) state_d = HasParity ? StParity : StStop;
      StParity: if (decide) state_d = StStop;
      StStop:   if (decide && bit_q == LastStop) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != StIdle);
    frame_done = (state_q == StStop) && decide && (bit_q == LastStop);
    ferr_final = ferr_q | ~maj;
    brk        = (data_q == '0) && !par_bit_q && ferr_final;
    entry      = {brk, ferr_final, perr_q, data_q};
  end

  // After the t0 edge cnt_q holds 1, so cnt_q equals the clock offset within the current bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      bit_q     <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      cnt_q     <= start_ok ? CntW'(1) : '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntSmp0) s0_q <= rxs_q;
      if (cnt_q == CntSmp1) s1_q <= rxs_q;
      if (decide) begin
        case (state_q)
          StData: begin
            data_q <= {maj, data_q[p_WORD_LEN-1:1]};
            bit_q  <= (bit_q == LastData) ? '0 : bit_q + 4'd1;
          end
          StParity: begin
            par_bit_q <= maj;
            perr_q    <= par_mismatch;
          end
          StStop: begin
            ferr_q <= ferr_final;
            bit_q  <= bit_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [EntW-1:0] mem_q [p_FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            overflow_q, full, rd_en, wr_en;
  logic [EntW-1:0] head;

  assign full  = (count_q == CntFull);
  assign rd_en = i_rd & o_dv;
  assign wr_en = frame_done & (~full | rd_en);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wptr_q] <= entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (rd_en) rptr_q <= rptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: ;
      endcase
      overflow_q <= frame_done & full & ~rd_en;
    end
  end

  assign head         = mem_q[rptr_q];
  assign o_dv         = (count_q != '0);
  assign o_count      = count_q;
  assign o_overflow   = overflow_q;
  assign o_data       = o_dv ? head[p_WORD_LEN-1:0] : '0;
  assign o_parity_err = o_dv & head[p_WORD_LEN];
  assign o_frame_err  = o_dv & head[p_WORD_LEN+1];
  assign o_break      = o_dv & head[p_WORD_LEN+2];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit, 8 data bits, even parity, 1 stop, depth 4.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n, rx, rd;
  logic [7:0] data;
  logic       parity_err, frame_err, brk, dv, overflow, busy;
  logic [2:0] count;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ovf_cnt = 0;
  int dv_rise_cyc = -1;
  logic dv_prev = 1'b0;

  uart_rx_fifo #(
    .p_CLK_DIV   (16),
    .p_WORD_LEN  (8),
    .p_PARITY    (2),
    .p_STOP_BITS (1),
    .p_FIFO_DEPTH(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .i_rd        (rd),
    .o_data      (data),
    .o_parity_err(parity_err),
    .o_frame_err (frame_err),
    .o_break     (brk),
    .o_dv        (dv),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
    if (dv === 1'b1 && dv_prev !== 1'b1) dv_rise_cyc = cyc;
    dv_prev = dv;
  end

  // Entered on a negedge; each of the 11 bits is held for 16 clocks.
  task automatic send_frame(input logic [7:0] d, input logic par, input int gbit,
                            input logic rd_at_wr);
    logic [10:0] fb;
    fb = {1'b1, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < 16; j++) begin
        rx = (k == gbit && j == 8) ? ~fb[k] : fb[k];
        rd = rd_at_wr && (k == 10) && (j == 11);
        @(negedge clk);
      end
    end
    rx = 1'b1;
    rd = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    rd    = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (dv !== 1'b0) $display("FAIL rst_dv got %b want 0", dv); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else passed++;
    total++; if (data !== 8'h00) $display("FAIL rst_data got %h want 00", data); else passed++;
    total++;
    if ({parity_err, frame_err, brk, overflow, busy} !== 5'b0)
      $display("FAIL rst_flags got %b want 00000", {parity_err, frame_err, brk, overflow, busy});
    else passed++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_busy_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_clean_frame();
    int c0;
    c0 = cyc;
    dv_rise_cyc = -1;
    send_frame(8'hA5, 1'b0, -1, 1'b0);
    total++;
    if (dv_rise_cyc != c0 + 172) $display("FAIL clean_dv_time got %0d want %0d", dv_rise_cyc, c0 + 172);
    else passed++;
    total++; if (data !== 8'hA5) $display("FAIL clean_data got %h want a5", data); else passed++;
    total++;
    if ({parity_err, frame_err, brk} !== 3'b000)
      $display("FAIL clean_flags got %b want 000", {parity_err, frame_err, brk});
    else passed++;
    pop();
    total++; if (dv !== 1'b0) $display("FAIL clean_pop_dv got %b want 0", dv); else passed++;
  endtask

  task automatic test_parity_glitch();
    send_frame(8'h3C, 1'b1, -1, 1'b0);
    total++; if (data !== 8'h3C) $display("FAIL perr_data got %h want 3c", data); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL perr_flag got %b want 1", parity_err); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL perr_ferr got %b want 0", frame_err); else passed++;
    pop();
    // Frame bit 3 is data bit 2; the glitch lands on its middle sample.
    send_frame(8'h3C, 1'b1, 3, 1'b0);
    total++; if (data !== 8'h3C) $display("FAIL glitch_data got %h want 3c", data); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL glitch_perr got %b want 1", parity_err); else passed++;
    pop();
    total++; if (count !== 3'd0) $display("FAIL glitch_count got %0d want 0", count); else passed++;
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL fs_busy_high got %b want 1", busy); else passed++;
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL fs_busy_low got %b want 0", busy); else passed++;
    repeat (200) @(negedge clk);
    total++; if (count !== 3'd0) $display("FAIL fs_count got %0d want 0", count); else passed++;
    total++; if (dv !== 1'b0) $display("FAIL fs_dv got %b want 0", dv); else passed++;
  endtask

  task automatic test_break();
    rx = 1'b0;
    repeat (176) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (count !== 3'd1) $display("FAIL brk_count got %0d want 1", count); else passed++;
    total++; if (data !== 8'h00) $display("FAIL brk_data got %h want 00", data); else passed++;
    total++; if (frame_err !== 1'b1) $display("FAIL brk_ferr got %b want 1", frame_err); else passed++;
    total++; if (brk !== 1'b1) $display("FAIL brk_flag got %b want 1", brk); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL brk_perr got %b want 0", parity_err); else passed++;
    pop();
    total++; if (dv !== 1'b0) $display("FAIL brk_pop_dv got %b want 0", dv); else passed++;
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] d;
    base = ovf_cnt;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, ^d, -1, 1'b0);
    end
    total++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else passed++;
    total++;
    if (ovf_cnt - base != 1) $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - base);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (data !== 8'(i)) $display("FAIL ovf_order%0d got %h want %h", i, data, 8'(i));
      else passed++;
      pop();
    end
    total++; if (dv !== 1'b0) $display("FAIL ovf_drained_dv got %b want 0", dv); else passed++;
  endtask

  task automatic test_full_rw();
    int base;
    logic [7:0] exp_q [4];
    send_frame(8'h11, ^8'h11, -1, 1'b0);
    send_frame(8'h22, ^8'h22, -1, 1'b0);
    send_frame(8'h33, ^8'h33, -1, 1'b0);
    send_frame(8'h44, ^8'h44, -1, 1'b0);
    base = ovf_cnt;
    send_frame(8'h55, ^8'h55, -1, 1'b1);
    total++; if (count !== 3'd4) $display("FAIL fullrw_count got %0d want 4", count); else passed++;
    total++;
    if (ovf_cnt != base) $display("FAIL fullrw_ovf got %0d want 0", ovf_cnt - base);
    else passed++;
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data !== exp_q[i]) $display("FAIL fullrw_order%0d got %h want %h", i, data, exp_q[i]);
      else passed++;
      pop();
    end
    total++; if (dv !== 1'b0) $display("FAIL fullrw_dv got %b want 0", dv); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] fb;
    send_frame(8'h66, ^8'h66, -1, 1'b0);
    send_frame(8'h77, ^8'h77, -1, 1'b0);
    fb = {1'b1, ^8'h88, 8'h88, 1'b0};
    // 4.5 bit times in: halfway through data bit 3.
    for (int n = 0; n < 72; n++) begin
      rx = fb[n / 16];
      @(negedge clk);
    end
    total++; if (count !== 3'd2) $display("FAIL mid_pre_count got %0d want 2", count); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL mid_pre_busy got %b want 1", busy); else passed++;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    total++; if (count !== 3'd0) $display("FAIL mid_rst_count got %0d want 0", count); else passed++;
    total++;
    if ({dv, busy, overflow, parity_err, frame_err, brk} !== 6'b0 || data !== 8'h00)
      $display("FAIL mid_rst_outputs got %b/%h want 000000/00",
               {dv, busy, overflow, parity_err, frame_err, brk}, data);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (count !== 3'd0) $display("FAIL mid_post_count got %0d want 0", count); else passed++;
    send_frame(8'h5A, 1'b0, -1, 1'b0);
    total++; if (count !== 3'd1) $display("FAIL mid_rx_count got %0d want 1", count); else passed++;
    total++; if (data !== 8'h5A) $display("FAIL mid_rx_data got %h want 5a", data); else passed++;
    total++;
    if ({parity_err, frame_err, brk} !== 3'b000)
      $display("FAIL mid_rx_flags got %b want 000", {parity_err, frame_err, brk});
    else passed++;
    pop();
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    rd    = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_parity_glitch();
    test_false_start();
    test_break();
    test_overflow();
    test_full_rw();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the next generation of the team's 8N1 receiver. It adds configurable frame format (word length, parity, stop bits), 3-sample majority voting, and per-word parity, framing and break detection. Received words land in an internal first-word-fall-through FIFO, so a slow consumer can drain bursts. It sits between the pad-side serial input and the host-side byte consumer, and pairs with the team's UART transmitter at the same `p_CLK_DIV`.

## Interface
- `p_CLK_DIV`, default 104: clocks per bit; legal range ≥ 4.
- `p_WORD_LEN`, default 8: data bits per frame; legal range 5–9.
- `p_PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `p_STOP_BITS`, default 1: 1 or 2.
- `p_FIFO_DEPTH`, default 4: number of entries; power of 2, ≥ 2.

- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_rx` in 1: serial line, asynchronous to `i_clk`, idle high.
- `i_rd` in 1: pop the head entry; ignored when `o_dv`=0.
- `o_data` out `p_WORD_LEN`: head entry data.
- `o_parity_err` out 1: head entry parity mismatch; always 0 when `p_PARITY`=0.
- `o_frame_err` out 1: head entry had at least one stop bit sampled 0.
- `o_break` out 1: head entry had all data bits 0, parity bit 0 (if present) and `o_frame_err`=1.
- `o_dv` out 1: FIFO non-empty.
- `o_count` out clog2(`p_FIFO_DEPTH`)+1: FIFO occupancy.
- `o_overflow` out 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- `o_busy` out 1: receive FSM not in IDLE.

## Operation
- **Input synchroniser:** `i_rx` passes through a 2-flop synchroniser; both flops reset to 1. `rxs` denotes the synchronised value.
- **Frame length:** N = 1 + `p_WORD_LEN` + (`p_PARITY`≠0) + `p_STOP_BITS` bits.
- **Timebase:**
  - t0 is the edge at which `rxs`=0 is first seen in IDLE.
  - The bit counter k starts at 0 (the start bit) and the clock counter c at 0; c wraps at `p_CLK_DIV`-1.
  - M = `p_CLK_DIV`/2, integer division.
  - Each bit is sampled at c = M-1, M and M+1. The bit value is the majority of the 3 samples, decided at c = M+1.
- **FSM: IDLE → START → DATA → PARITY (skipped if `p_PARITY`=0) → STOP → IDLE.**
  - START: if the majority is 1, the start is false. Return to IDLE; nothing is written.
  - DATA: shifts bits in LSB first.
  - PARITY: compares the received bit with the computed parity. Odd mode expects an odd count of ones over data+parity; even mode expects an even count.
  - STOP: samples `p_STOP_BITS` bits; any 0 sets the frame error.
- **Return to IDLE:** on the decision edge of the last stop bit, the entry {break, frame_err, parity_err, data} is written to the FIFO and the FSM goes to IDLE in the same edge. The remaining half-bit is not waited out, so a new start edge is detected immediately.
- **FIFO pop:** `i_rd` with `o_dv`=1 pops on that edge; head outputs update on the next cycle.
- **Full FIFO:**
  - Write with no read: the word is dropped, `o_overflow` pulses and contents are unchanged.
  - Simultaneous write and `i_rd`: both succeed and there is no overflow.
- **Empty FIFO:** a write makes the entry visible on head outputs the next cycle.
- **Pointers:** read and write pointers wrap modulo `p_FIFO_DEPTH`. The count never exceeds `p_FIFO_DEPTH`.

## Timing
- **Reset values:**
  - Outputs: `o_data`=0, all flags 0, `o_dv`=0, `o_count`=0, `o_overflow`=0, `o_busy`=0.
  - Internal: FSM in IDLE, counters 0, FIFO empty.
- **Reset mid-frame:** the frame in progress is abandoned with no write, and FIFO contents are discarded. After release, the line must be seen high before a start is accepted.
- **Input latency:** an `i_rx` falling edge reaches t0 2–3 edges later.
- **Decision edge:** bit k is decided at t0 + k·`p_CLK_DIV` + M + 1.
- **Write edge:** the FIFO write occurs at t0 + (N-1)·`p_CLK_DIV` + M + 1. `o_dv` is high after that edge if the FIFO was empty.
  - Example at `p_CLK_DIV`=16, 8 data bits, no parity, 1 stop: write at t0+153.
- **`o_busy`:** high from t0 up to and including the write edge. On a false start it drops after t0+M+1.
- **`o_count`:** updates on the same edge as the write or pop.

## Test plan
Configuration: `p_CLK_DIV`=16, `p_WORD_LEN`=8, `p_PARITY`=2, `p_STOP_BITS`=1, `p_FIFO_DEPTH`=4.

1. **Clean frame:** send 0xA5 with parity 0 and stop 1 → `o_dv` rises at t0+169, `o_data`=0xA5, `o_parity_err`=0, `o_frame_err`=0, `o_break`=0.
2. **Parity error and glitch immunity:**
   - Send 0x3C with parity bit 1 → `o_parity_err`=1, `o_data`=0x3C.
   - Repeat with a single-cycle inverted pulse at c=M of data bit 2 → the data is still 0x3C.
3. **False start:** drive `i_rx` low for 4 clocks → no FIFO write, `o_count`=0, and `o_busy` falls by t0+10.
4. **Break:** hold `i_rx` low for 11 bit times, then release → one entry with `o_data`=0x00, `o_frame_err`=1, `o_break`=1. The line returning high causes no spurious frame.
5. **Overflow and ordering:** send 5 back-to-back frames 0x01–0x05 with no reads → `o_count`=4 and a single `o_overflow` pulse on the 5th write. Pops then return 0x01, 0x02, 0x03, 0x04, after which `o_dv`=0. A further check: a write coinciding with `i_rd` while full gives no overflow.
6. **Reset mid-frame:** assert `i_rst_n`=0 during data bit 3 with 2 entries queued → all outputs reset and `o_count`=0. After release, 0x5A is received cleanly with no errors.
